// File: rtl/float_to_int_seq_if.sv
// Handshake bundle between the FPU result path and the float-to-int converter.
interface float_to_int_seq_if #(
  parameter int unsigned float_size = 32,
  parameter int unsigned int_size   = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [float_size-1:0] float_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [int_size-1:0]   int_out;
  logic                  overflow;
  logic                  invalid;

  // Producer/consumer side.
  modport master (
    output in_valid, float_in, out_ready,
    input  in_ready, out_valid, int_out, overflow, invalid
  );

  // Converter side.
  modport slave (
    input  in_valid, float_in, out_ready,
    output in_ready, out_valid, int_out, overflow, invalid
  );
endinterface

// File: rtl/float_to_int_seq.sv
// Sequential float -> signed integer converter. Truncates toward zero, saturates out-of-range
// values, and aligns the significand with a one-bit-per-cycle shifter.
module float_to_int_seq #(
  parameter int unsigned float_size = 32,
  parameter int unsigned int_size   = 16
) (
  input logic              clk,
  input logic              reset,
  float_to_int_seq_if.slave io_bus
);

  function automatic int unsigned exponent_size(input int unsigned fs);
    case (fs)
      16:      return 5;
      64:      return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int unsigned exponent_biais(input int unsigned fs);
    return (32'd1 << (exponent_size(fs) - 1)) - 1;
  endfunction

  localparam int unsigned ExpW = exponent_size(float_size);
  localparam int unsigned Bias = exponent_biais(float_size);
  localparam int unsigned ManW = float_size - 1 - ExpW;
  localparam int unsigned AccW = (ManW + 1 > int_size) ? ManW + 1 : int_size;
  localparam int unsigned CntW = $clog2(AccW + 1);

  localparam logic [int_size-1:0] IntMax = {1'b0, {(int_size-1){1'b1}}};
  localparam logic [int_size-1:0] IntMin = {1'b1, {(int_size-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StClassify, StShift, StSign, StDone} state_e;

  state_e                r_state, w_state_d;
  logic [float_size-1:0] r_op, w_op_d;
  logic [AccW-1:0]       r_acc, w_acc_d;
  logic [CntW-1:0]       r_cnt, w_cnt_d;
  logic                  r_dir, w_dir_d;  // 1 = shift right
  logic [int_size-1:0]   r_int, w_int_d;
  logic                  r_ovf, w_ovf_d;
  logic                  r_inv, w_inv_d;
  logic                  r_out_valid, w_out_valid_d;

  logic                  w_sign;
  logic [ExpW-1:0]       w_exp;
  logic [ManW-1:0]       w_man;
  int                    w_ex;
  int                    w_diff;
  logic [CntW-1:0]       w_shift_cnt;
  logic                  w_exp_ones, w_nan, w_small, w_big, w_min_exact, w_special;

  // Decode the latched operand.
  always_comb begin
    w_sign      = r_op[float_size-1];
    w_exp       = r_op[float_size-2 -: ExpW];
    w_man       = r_op[ManW-1:0];
    w_ex        = int'(w_exp) - int'(Bias);
    w_diff      = w_ex - int'(ManW);
    w_shift_cnt = (w_diff < 0) ? CntW'(-w_diff) : CntW'(w_diff);
    w_exp_ones  = &w_exp;
    w_nan       = w_exp_ones && (w_man != '0);
    w_small     = (w_exp == '0) || (w_ex < 0);
    w_big       = w_ex >= (int'(int_size) - 1);
    // -2^(int_size-1) is exactly representable and is not an overflow.
    w_min_exact = w_sign && (w_ex == int'(int_size) - 1) && (w_man == '0);
    w_special   = w_exp_ones || (!w_small && w_big);
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:     if (io_bus.in_valid) w_state_d = StClassify;
      StClassify: begin
        if (w_special)                                 w_state_d = StDone;
        else if (!w_small && (w_shift_cnt != '0))      w_state_d = StShift;
        else                                           w_state_d = StSign;
      end
      StShift:    if (r_cnt == CntW'(1)) w_state_d = StSign;
      StSign:     w_state_d = StDone;
      StDone:     if (r_out_valid && io_bus.out_ready) w_state_d = StIdle;
      default:    w_state_d = StIdle;
    endcase
  end

  // Handshake outputs and result drive.
  always_comb begin
    io_bus.in_ready  = (r_state == StIdle);
    io_bus.out_valid = r_out_valid;
    io_bus.int_out   = r_int;
    io_bus.overflow  = r_ovf;
    io_bus.invalid   = r_inv;
  end

  // Datapath next values: operand latch, classification, alignment shift, sign apply.
  always_comb begin
    w_op_d  = r_op;
    w_acc_d = r_acc;
    w_cnt_d = r_cnt;
    w_dir_d = r_dir;
    w_int_d = r_int;
    w_ovf_d = r_ovf;
    w_inv_d = r_inv;
    unique case (r_state)
      StIdle: begin
        if (io_bus.in_valid) begin
          w_op_d  = io_bus.float_in;
          w_int_d = '0;
          w_ovf_d = 1'b0;
          w_inv_d = 1'b0;
        end
      end
      StClassify: begin
        if (w_nan) begin
          w_int_d = IntMax;
          w_inv_d = 1'b1;
        end else if (w_exp_ones) begin
          w_int_d = w_sign ? IntMin : IntMax;
          w_ovf_d = 1'b1;
        end else if (w_small) begin
          w_acc_d = '0;
        end else if (w_big) begin
          w_int_d = w_sign ? IntMin : IntMax;
          w_ovf_d = !w_min_exact;
        end else begin
          w_acc_d = AccW'({1'b1, w_man});
          w_cnt_d = w_shift_cnt;
          w_dir_d = (w_diff < 0);
        end
      end
      StShift: begin
        w_acc_d = r_dir ? (r_acc >> 1) : (r_acc << 1);
        w_cnt_d = r_cnt - CntW'(1);
      end
      StSign: begin
        w_int_d = w_sign ? (-r_acc[int_size-1:0]) : r_acc[int_size-1:0];
      end
      default: ;
    endcase
  end

  // out_valid rises one edge after DONE is entered and drops on the accepting edge.
  assign w_out_valid_d = (r_state == StDone) && (w_state_d == StDone);

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_op        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_dir       <= 1'b0;
      r_int       <= '0;
      r_ovf       <= 1'b0;
      r_inv       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_op        <= w_op_d;
      r_acc       <= w_acc_d;
      r_cnt       <= w_cnt_d;
      r_dir       <= w_dir_d;
      r_int       <= w_int_d;
      r_ovf       <= w_ovf_d;
      r_inv       <= w_inv_d;
      r_out_valid <= w_out_valid_d;
    end
  end

endmodule

// File: tb/tb_float_to_int_seq.sv
// Bench for float_to_int_seq at float_size=32, int_size=16.
module tb_float_to_int_seq;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  float_to_int_seq_if #(.float_size(32), .int_size(16)) bus ();

  float_to_int_seq #(.float_size(32), .int_size(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] f;
    logic [15:0] res;
    logic        ovf;
    logic        inv;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Reference: exact real-valued interpretation, truncation via $rtoi, then range clamp.
  function automatic void model(input logic [31:0] f, output logic [15:0] r, output logic o,
                                output logic iv, output int lat);
    logic s;
    int   e, ex, t;
    real  v;
    s  = f[31];
    e  = int'(f[30:23]);
    ex = e - 127;
    r  = 16'h0000;
    o  = 1'b0;
    iv = 1'b0;
    if (e == 255) begin
      lat = 2;
      if (f[22:0] != 23'd0) begin
        r  = 16'h7FFF;
        iv = 1'b1;
      end else begin
        r = s ? 16'h8000 : 16'h7FFF;
        o = 1'b1;
      end
      return;
    end
    if (e == 0) v = 0.0;
    else begin
      v = 1.0 + real'(f[22:0]) / 8388608.0;
      for (int i = 0; i < ex; i++) v = v * 2.0;
      for (int i = 0; i > ex; i--) v = v / 2.0;
    end
    if (s) v = -v;
    if (e == 0 || ex < 0) lat = 3;
    else if (ex >= 15)    lat = 2;
    else                  lat = 3 + ((ex > 23) ? ex - 23 : 23 - ex);
    if (v >= 32768.0) begin
      r = 16'h7FFF;
      o = 1'b1;
    end else if (v < -32768.0) begin
      r = 16'h8000;
      o = 1'b1;
    end else begin
      t = $rtoi(v);
      r = t[15:0];
    end
  endfunction

  // Present one operand, wait for the result, optionally consume it.
  task automatic convert(input logic [31:0] f, input bit release_it, output logic [15:0] r,
                         output logic o, output logic iv, output int lat);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (!bus.in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL in_ready_timeout: got 0 expected 1");
    end
    bus.in_valid = 1'b1;
    bus.float_in = f;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) begin
      n_vec++;
      n_fail++;
      $display("FAIL out_valid_timeout f=%h: got 0 expected 1", f);
      lat = -1;
    end
    r  = bus.int_out;
    o  = bus.overflow;
    iv = bus.invalid;
    if (release_it) begin
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
    end
  endtask

  initial begin
    logic [15:0] r, mr;
    logic        o, iv, mo, miv;
    int          lat, mlat;
    logic [31:0] f;
    logic [7:0]  e;
    logic        s;
    int          sel;

    vecs[0]  = '{32'h3F800000, 16'h0001, 1'b0, 1'b0, 26};
    vecs[1]  = '{32'hC2F6E979, 16'hFF85, 1'b0, 1'b0, 20};
    vecs[2]  = '{32'h449A4000, 16'h04D2, 1'b0, 1'b0, 16};
    vecs[3]  = '{32'h3F000000, 16'h0000, 1'b0, 1'b0, 3};
    vecs[4]  = '{32'h80000000, 16'h0000, 1'b0, 1'b0, 3};
    vecs[5]  = '{32'h47000000, 16'h7FFF, 1'b1, 1'b0, 2};
    vecs[6]  = '{32'hC7000000, 16'h8000, 1'b0, 1'b0, 2};
    vecs[7]  = '{32'hC7000080, 16'h8000, 1'b1, 1'b0, 2};
    vecs[8]  = '{32'h46FFFE00, 16'h7FFF, 1'b0, 1'b0, 12};
    vecs[9]  = '{32'h7FC00000, 16'h7FFF, 1'b0, 1'b1, 2};
    vecs[10] = '{32'hFF800000, 16'h8000, 1'b1, 1'b0, 2};
    vecs[11] = '{32'h40000000, 16'h0002, 1'b0, 1'b0, 25};

    bus.in_valid  = 1'b0;
    bus.float_in  = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_int_out", 32'(bus.int_out), 32'd0);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    check("rst_invalid", 32'(bus.invalid), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 12; i++) begin
      convert(vecs[i].f, 1'b1, r, o, iv, lat);
      check($sformatf("vec%0d_int f=%h", i, vecs[i].f), 32'(r), 32'(vecs[i].res));
      check($sformatf("vec%0d_ovf f=%h", i, vecs[i].f), 32'(o), 32'(vecs[i].ovf));
      check($sformatf("vec%0d_inv f=%h", i, vecs[i].f), 32'(iv), 32'(vecs[i].inv));
      check($sformatf("vec%0d_lat f=%h", i, vecs[i].f), 32'(lat), 32'(vecs[i].lat));
    end

    // Backpressure: result must hold while out_ready is low.
    convert(32'h3F800000, 1'b0, r, o, iv, lat);
    check("bp_first_int", 32'(r), 32'h0001);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d_int", c), 32'(bus.int_out), 32'h0001);
      check($sformatf("bp_hold%0d_in_ready", c), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp_hold%0d_out_valid", c), 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    convert(32'h40000000, 1'b1, r, o, iv, lat);
    check("bp_second_int", 32'(r), 32'h0002);

    // Reset in the middle of the alignment shift.
    bus.in_valid = 1'b1;
    bus.float_in = 32'h3F800000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mrst_int_out", 32'(bus.int_out), 32'd0);
    check("mrst_overflow", 32'(bus.overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("mrst_idle_out_valid", 32'(bus.out_valid), 32'd0);
    convert(32'h41200000, 1'b1, r, o, iv, lat);
    check("mrst_ten_int", 32'(r), 32'h000A);
    check("mrst_ten_lat", 32'(lat), 32'd23);

    // Randomised operands against the reference model.
    for (int i = 0; i < 200; i++) begin
      sel = int'($urandom_range(0, 9));
      s   = 1'($urandom_range(0, 1));
      if (sel < 7) begin
        e = 8'(125 + $urandom_range(0, 18));
        f = {s, e, 23'($urandom)};
      end else if (sel == 7) begin
        f = $urandom;
      end else if (sel == 8) begin
        f = {s, 8'hFF, ($urandom_range(0, 1) == 0) ? 23'd0 : 23'($urandom)};
      end else begin
        f = {s, 8'h00, 23'($urandom)};
      end
      model(f, mr, mo, miv, mlat);
      convert(f, 1'b1, r, o, iv, lat);
      check($sformatf("rnd%0d_int f=%h", i, f), 32'(r), 32'(mr));
      check($sformatf("rnd%0d_ovf f=%h", i, f), 32'(o), 32'(mo));
      check($sformatf("rnd%0d_inv f=%h", i, f), 32'(iv), 32'(miv));
      check($sformatf("rnd%0d_lat f=%h", i, f), 32'(lat), 32'(mlat));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
